// File: rtl/spi_drx_pkg.sv
// Shared constants for the SPI DSP receive register: Avalon word addresses
// and bit positions inside the STATUS, CTRL and CLEAR registers.
package spi_drx_pkg;

  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVR_BIT   = 2;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_LEVEL_W   = 8;

  localparam int CTRL_IRQ_DATA_BIT = 0;
  localparam int CTRL_IRQ_OVR_BIT  = 1;

  localparam int CLR_OVR_BIT   = 0;
  localparam int CLR_FLUSH_BIT = 1;

endpackage

// File: rtl/spi_drx_fifo.sv
// Synchronous FIFO for received SPI words with push, pop and flush.
// A push while full is accepted only when a pop happens in the same cycle.
module spi_drx_fifo
  import spi_drx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 8,
  localparam int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head,
  output logic [LEVEL_W-1:0] level,
  output logic [LEVEL_W-1:0] level_next,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [LEVEL_W-1:0] level_r;
  logic               pop_ok_s;
  logic               push_ok_s;

  assign empty    = (level_r == {LEVEL_W{1'b0}});
  assign full     = (level_r == LEVEL_W'(DEPTH));
  assign pop_ok_s = pop & ~empty;
  // Flush discards a concurrent push; a full FIFO makes room only via a same-cycle pop.
  assign push_ok_s = push & ~flush & (~full | pop_ok_s);
  assign head      = mem_r[rd_ptr_r];
  assign level     = level_r;

  // Occupancy after this edge
  always_comb begin
    level_next = level_r;
    if (flush) begin
      level_next = {LEVEL_W{1'b0}};
    end else if (push_ok_s && !pop_ok_s) begin
      level_next = level_r + LEVEL_W'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      level_next = level_r - LEVEL_W'(1);
    end else begin
      level_next = level_r;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LEVEL_W{1'b0}};
    end else begin
      level_r <= level_next;
      if (flush) begin
        rd_ptr_r <= {PTR_W{1'b0}};
        wr_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Word storage
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/spi_drx_register.sv
// Avalon-MM receive register for the FPGA-DSP SPI link: FIFO, status, clear
// and, when DRX_IRQ_EN is defined, the CTRL register and level interrupt.
module spi_drx_register
  import spi_drx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 8,
  localparam int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  logic               rd_s;
  logic               wr_s;
  logic               pop_s;
  logic               flush_s;
  logic               clr_ovr_s;
  logic               ovr_set_s;
  logic               overrun_r;
  logic               overrun_next_s;
  logic [1:0]         ctrl_s;
  logic [DATA_W-1:0]  head_s;
  logic [LEVEL_W-1:0] level_s;
  logic [LEVEL_W-1:0] level_next_s;
  logic               empty_s;
  logic               full_s;
  logic [31:0]        rd_value_s;

  assign rd_s      = chipselect & ~read_n;
  assign wr_s      = chipselect & ~write_n;
  assign pop_s     = rd_s & (address == ADDR_DATA);
  assign flush_s   = wr_s & (address == ADDR_CLEAR) & writedata[CLR_FLUSH_BIT];
  assign clr_ovr_s = wr_s & (address == ADDR_CLEAR) & writedata[CLR_OVR_BIT];
  // A drop only happens when the word finds no room and is not discarded by a flush.
  assign ovr_set_s      = in_valid & full_s & ~(pop_s & ~empty_s) & ~flush_s;
  assign overrun_next_s = ovr_set_s | (overrun_r & ~clr_ovr_s);

  spi_drx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (in_valid),
    .push_data  (in_data),
    .pop        (pop_s),
    .flush      (flush_s),
    .head       (head_s),
    .level      (level_s),
    .level_next (level_next_s),
    .empty      (empty_s),
    .full       (full_s)
  );

  // Read mux, sampled on pre-edge state
  always_comb begin
    rd_value_s = 32'h0000_0000;
    case (address)
      ADDR_DATA: begin
        if (empty_s) rd_value_s = 32'h0000_0000;
        else         rd_value_s = 32'(head_s);
      end
      ADDR_STATUS: begin
        rd_value_s[STAT_EMPTY_BIT] = empty_s;
        rd_value_s[STAT_FULL_BIT]  = full_s;
        rd_value_s[STAT_OVR_BIT]   = overrun_r;
        rd_value_s[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(level_s);
      end
      ADDR_CTRL: rd_value_s = 32'(ctrl_s);
      default:   rd_value_s = 32'h0000_0000;
    endcase
  end

  // Registered read data and sticky overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata  <= 32'h0000_0000;
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_next_s;
      if (rd_s) readdata <= rd_value_s;
    end
  end

`ifdef DRX_IRQ_EN
  logic [1:0] ctrl_r;
  logic       irq_next_s;
  logic       unused_s;

  assign ctrl_s     = ctrl_r;
  assign irq_next_s = (ctrl_r[CTRL_IRQ_DATA_BIT] & (level_next_s != {LEVEL_W{1'b0}})) |
                      (ctrl_r[CTRL_IRQ_OVR_BIT] & overrun_next_s);
  assign unused_s   = &{1'b0, writedata[31:2]};

  // Interrupt enables and registered interrupt level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_r <= 2'b00;
      irq    <= 1'b0;
    end else begin
      irq <= irq_next_s;
      if (wr_s && (address == ADDR_CTRL)) ctrl_r <= writedata[1:0];
    end
  end
`else
  logic unused_s;

  assign ctrl_s   = 2'b00;
  assign irq      = 1'b0;
  assign unused_s = &{1'b0, writedata[31:2], level_next_s};
`endif

endmodule
